// File: rtl/l2_lookup_arbiter.sv
// Arbitrates the shared L2 tag/state arrays between CPU requests and forwards,
// sequencing read, single-cycle lookup and a held result until the consumer accepts.
`ifndef L2_LOOKUP
`define L2_LOOKUP 1'b0
`endif
`ifndef L2_LOOKUP_FWD
`define L2_LOOKUP_FWD 1'b1
`endif

module l2_lookup_arbiter #(
  parameter int SET_BITS       = 9,
  parameter int RD_LAT         = 1,
  parameter int MAX_FWD_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [SET_BITS-1:0] req_set,
  input  logic                req_block,
  output logic                req_ready,
  input  logic                fwd_valid,
  input  logic [SET_BITS-1:0] fwd_set,
  output logic                fwd_ready,
  output logic                rd_en,
  output logic [SET_BITS-1:0] rd_set,
  output logic                lookup_en,
  output logic                lookup_mode,
  input  logic                tag_hit_next,
  output logic                done_valid,
  output logic                done_fwd,
  output logic                done_hit,
  input  logic                done_ready
);

  localparam int STREAK_W = (MAX_FWD_STREAK < 1) ? 1 : $clog2(MAX_FWD_STREAK + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_LOOKUP,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SET_BITS-1:0] r_set;
  logic                r_mode;
  logic [1:0]          r_cnt;
  logic [STREAK_W-1:0] r_streak;
  logic                r_done_hit;
  logic                r_done_fwd;

  logic w_idle;
  logic w_req_elig;
  logic w_streak_sat;
  logic w_grant_fwd;
  logic w_grant_req;
  logic w_read_last;

  // Readies are masked by rst so every output is quiet while reset is held.
  assign w_idle       = (r_state == S_IDLE) && !rst;
  assign w_req_elig   = req_valid & ~req_block;
  assign w_streak_sat = (r_streak == STREAK_W'(MAX_FWD_STREAK));
  assign w_grant_fwd  = w_idle & fwd_valid & ~(w_req_elig & w_streak_sat);
  assign w_grant_req  = w_idle & ~w_grant_fwd & w_req_elig;
  assign w_read_last  = (r_cnt == 2'(RD_LAT - 1));

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    fwd_ready   = 1'b0;
    rd_en       = 1'b0;
    rd_set      = r_set;
    lookup_en   = 1'b0;
    lookup_mode = r_mode;
    done_valid  = 1'b0;
    done_fwd    = r_done_fwd;
    done_hit    = r_done_hit;
    case (r_state)
      S_IDLE: begin
        req_ready = w_grant_req;
        fwd_ready = w_grant_fwd;
        if (w_grant_fwd || w_grant_req) w_state_nxt = S_READ;
      end
      S_READ: begin
        rd_en = (r_cnt == 2'd0);
        if (w_read_last) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        lookup_en   = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_valid = 1'b1;
        if (done_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_set      <= '0;
      r_mode     <= `L2_LOOKUP;
      r_cnt      <= 2'd0;
      r_streak   <= '0;
      r_done_hit <= 1'b0;
      r_done_fwd <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_fwd || w_grant_req) begin
        r_set  <= w_grant_fwd ? fwd_set : req_set;
        r_mode <= w_grant_fwd ? `L2_LOOKUP_FWD : `L2_LOOKUP;
        r_cnt  <= 2'd0;
      end else if (r_state == S_READ) begin
        r_cnt <= r_cnt + 2'd1;
      end
      // Streak only grows while an eligible request is actually being passed over.
      if (w_grant_fwd) begin
        if (!w_req_elig)        r_streak <= '0;
        else if (!w_streak_sat) r_streak <= r_streak + 1'b1;
      end else if (w_grant_req) begin
        r_streak <= '0;
      end
      if (r_state == S_LOOKUP) begin
        r_done_hit <= tag_hit_next;
        r_done_fwd <= r_mode;
      end
    end
  end

endmodule

// File: tb/tb_l2_lookup_arbiter.sv
// Directed bench for l2_lookup_arbiter: three instances (RD_LAT 1..3) share clock and reset,
// one instance is exercised at a time; completed lookups are checked against a queue.
`ifndef L2_LOOKUP
`define L2_LOOKUP 1'b0
`endif
`ifndef L2_LOOKUP_FWD
`define L2_LOOKUP_FWD 1'b1
`endif

module tb_l2_lookup_arbiter;
  localparam int SB = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          req_valid    [1:3];
  logic [SB-1:0] req_set      [1:3];
  logic          req_block    [1:3];
  logic          req_ready    [1:3];
  logic          fwd_valid    [1:3];
  logic [SB-1:0] fwd_set      [1:3];
  logic          fwd_ready    [1:3];
  logic          rd_en        [1:3];
  logic [SB-1:0] rd_set       [1:3];
  logic          lookup_en    [1:3];
  logic          lookup_mode  [1:3];
  logic          tag_hit_next [1:3];
  logic          done_valid   [1:3];
  logic          done_fwd     [1:3];
  logic          done_hit     [1:3];
  logic          done_ready   [1:3];

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    l2_lookup_arbiter #(.SET_BITS(SB), .RD_LAT(g), .MAX_FWD_STREAK(4)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_set(req_set[g]), .req_block(req_block[g]),
      .req_ready(req_ready[g]),
      .fwd_valid(fwd_valid[g]), .fwd_set(fwd_set[g]), .fwd_ready(fwd_ready[g]),
      .rd_en(rd_en[g]), .rd_set(rd_set[g]),
      .lookup_en(lookup_en[g]), .lookup_mode(lookup_mode[g]),
      .tag_hit_next(tag_hit_next[g]),
      .done_valid(done_valid[g]), .done_fwd(done_fwd[g]), .done_hit(done_hit[g]),
      .done_ready(done_ready[g])
    );
  end

  typedef struct packed {
    logic fwd;
    logic hit;
  } exp_t;

  exp_t       sbq[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] glog;
  int         ngr;
  int         n_reqrdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic pop_chk(input int k, input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed done_valid with empty queue expected no completion", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_done_fwd"}, done_fwd[k], e.fwd);
      chk({tag, "_done_hit"}, done_hit[k], e.hit);
    end
  endtask

  // Called at a negedge: scores completions and logs/pushes grants (1 = forward).
  task automatic sample(input int k);
    chk("ready_exclusive", req_ready[k] & fwd_ready[k], 1'b0);
    if (req_ready[k]) n_reqrdy++;
    if (done_valid[k] && done_ready[k]) pop_chk(k, "sb");
    if (fwd_valid[k] && fwd_ready[k]) begin
      glog = {glog[8:0], 1'b1};
      ngr++;
      sbq.push_back({1'b1, tag_hit_next[k]});
    end else if (req_valid[k] && req_ready[k]) begin
      glog = {glog[8:0], 1'b0};
      ngr++;
      sbq.push_back({1'b0, tag_hit_next[k]});
    end
  endtask

  task automatic run_grants(input int k, input int target, input int maxc);
    ngr  = 0;
    glog = '0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      sample(k);
      if (ngr == target) break;
    end
    chk("grant_count", ngr, target);
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    fwd_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      sample(k);
      if (sbq.size() == 0) break;
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected bench completion");
    $fatal(1, "timeout");
  end

  int lat;
  int n_lk;

  initial begin
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      req_valid[k] = 1'b0; req_set[k] = '0; req_block[k] = 1'b0;
      fwd_valid[k] = 1'b0; fwd_set[k] = '0;
      tag_hit_next[k] = 1'b0; done_ready[k] = 1'b1;
    end
    req_valid[1] = 1'b1;
    fwd_valid[2] = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      chk("rst_rd_en", rd_en[k], 1'b0);
      chk("rst_rd_set", rd_set[k], 9'h000);
      chk("rst_lookup_en", lookup_en[k], 1'b0);
      chk("rst_lookup_mode", lookup_mode[k], `L2_LOOKUP);
      chk("rst_done_valid", done_valid[k], 1'b0);
      chk("rst_done_fwd", done_fwd[k], 1'b0);
      chk("rst_done_hit", done_hit[k], 1'b0);
      chk("rst_req_ready", req_ready[k], 1'b0);
      chk("rst_fwd_ready", fwd_ready[k], 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid[1] = 1'b0;
    fwd_valid[2] = 1'b0;

    // Single forward, RD_LAT=1: cycle-by-cycle latency
    fwd_valid[1] = 1'b1;
    fwd_set[1]   = 9'h1A5;
    @(negedge clk);
    chk("t1_fwd_ready", fwd_ready[1], 1'b1);
    sample(1);
    @(posedge clk);
    #1;
    fwd_valid[1] = 1'b0;
    @(negedge clk);
    chk("t1_rd_en", rd_en[1], 1'b1);
    chk("t1_rd_set", rd_set[1], 9'h1A5);
    chk("t1_lookup_en_early", lookup_en[1], 1'b0);
    sample(1);
    @(negedge clk);
    chk("t1_lookup_en", lookup_en[1], 1'b1);
    chk("t1_lookup_mode", lookup_mode[1], `L2_LOOKUP_FWD);
    chk("t1_rd_en_once", rd_en[1], 1'b0);
    sample(1);
    @(negedge clk);
    chk("t1_done_valid", done_valid[1], 1'b1);
    sample(1);
    chk("t1_queue_empty", sbq.size(), 0);
    @(negedge clk);
    chk("t1_idle_done_valid", done_valid[1], 1'b0);

    // Both valid, held: starvation bound gives FFFFRFFFFR
    @(posedge clk);
    #1;
    req_set[1] = 9'h011; fwd_set[1] = 9'h022;
    req_valid[1] = 1'b1; fwd_valid[1] = 1'b1;
    run_grants(1, 10, 200);
    chk("t2_grant_order", glog, 10'b1111011110);
    drain(1, 20);

    // Blocked request: forwards only, req_ready never high, streak stays 0
    @(posedge clk);
    #1;
    n_reqrdy = 0;
    req_block[1] = 1'b1;
    req_valid[1] = 1'b1; fwd_valid[1] = 1'b1;
    run_grants(1, 10, 200);
    chk("t3_grant_order", glog, 10'b1111111111);
    chk("t3_req_ready_count", n_reqrdy, 0);
    drain(1, 20);
    @(posedge clk);
    #1;
    req_block[1] = 1'b0;
    req_valid[1] = 1'b1; fwd_valid[1] = 1'b1;
    run_grants(1, 5, 100);
    chk("t3_streak_restart", glog, 10'b0000011110);
    drain(1, 20);

    // Hit held through consumer backpressure
    @(posedge clk);
    #1;
    tag_hit_next[1] = 1'b1;
    done_ready[1]   = 1'b0;
    req_set[1]      = 9'h133;
    req_valid[1]    = 1'b1;
    @(negedge clk);
    chk("t4_req_ready", req_ready[1], 1'b1);
    sample(1);
    @(posedge clk);
    #1;
    fwd_valid[1] = 1'b1;
    @(negedge clk);
    sample(1);
    @(negedge clk);
    chk("t4_lookup_en", lookup_en[1], 1'b1);
    chk("t4_lookup_mode", lookup_mode[1], `L2_LOOKUP);
    sample(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_done_valid", done_valid[1], 1'b1);
      chk("t4_hold_done_hit", done_hit[1], 1'b1);
      chk("t4_hold_readies", {req_ready[1], fwd_ready[1]}, 2'b00);
      sample(1);
    end
    @(posedge clk);
    #1;
    done_ready[1] = 1'b1;
    @(negedge clk);
    chk("t4_accept_done_valid", done_valid[1], 1'b1);
    chk("t4_no_same_cycle_grant", fwd_ready[1], 1'b0);
    sample(1);
    @(negedge clk);
    chk("t4_regrant_fwd", fwd_ready[1], 1'b1);
    chk("t4_regrant_req", req_ready[1], 1'b0);
    sample(1);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0; fwd_valid[1] = 1'b0;
    drain(1, 20);
    tag_hit_next[1] = 1'b0;

    // Asynchronous reset during READ, RD_LAT=3
    @(posedge clk);
    #1;
    req_set[3] = 9'h055;
    req_valid[3] = 1'b1;
    @(negedge clk);
    chk("t5_req_ready", req_ready[3], 1'b1);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    @(negedge clk);
    chk("t5_rd_en", rd_en[3], 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_async_rd_en", rd_en[3], 1'b0);
    chk("t5_async_rd_set", rd_set[3], 9'h000);
    chk("t5_async_lookup_en", lookup_en[3], 1'b0);
    chk("t5_async_done_valid", done_valid[3], 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_lk = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (lookup_en[3]) n_lk++;
    end
    chk("t5_dropped_lookup", n_lk, 0);
    chk("t5_no_done", done_valid[3], 1'b0);
    @(posedge clk);
    #1;
    req_set[3] = 9'h0AA;
    req_valid[3] = 1'b1;
    @(negedge clk);
    chk("t5_reaccept", req_ready[3], 1'b1);
    sample(3);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("t5_rd_set", rd_set[3], 9'h0AA);
      sample(3);
      if (lookup_en[3]) break;
    end
    chk("t5_lookup_latency", lat, 4);
    drain(3, 20);

    // Request with RD_LAT=2
    @(posedge clk);
    #1;
    req_set[2] = 9'h0FF;
    req_valid[2] = 1'b1;
    @(negedge clk);
    chk("t6_req_ready", req_ready[2], 1'b1);
    sample(2);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("t6_rd_en_first", rd_en[2], 1'b1);
    chk("t6_rd_set_first", rd_set[2], 9'h0FF);
    sample(2);
    @(negedge clk);
    chk("t6_rd_en_second", rd_en[2], 1'b0);
    chk("t6_rd_set_second", rd_set[2], 9'h0FF);
    chk("t6_lookup_en_early", lookup_en[2], 1'b0);
    sample(2);
    @(negedge clk);
    chk("t6_lookup_en", lookup_en[2], 1'b1);
    chk("t6_lookup_mode", lookup_mode[2], `L2_LOOKUP);
    sample(2);
    @(negedge clk);
    chk("t6_done_valid", done_valid[2], 1'b1);
    sample(2);
    chk("t6_queue_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
